// File: rtl/score_pkg.sv
// score_pkg: shared 7-segment codes, decoder function, FSM state type and digit bound
// for bcd_score_counter.
package score_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0011000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {IDLE, ADD} state_t;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// seg7_digit_decoder: one BCD digit to active-low {g..a} segments, with forced blank.
module seg7_digit_decoder
   import score_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: N-digit packed-BCD score accumulator, digit-serial add, saturating,
// with 7-segment outputs. Define SCORE_HISCORE_EN to add the high-score register and outputs.
module bcd_score_counter
   import score_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  add_valid,
   output logic                  add_ready,
   input  logic [3:0]            add_pts,
   output logic [4*N_DIGITS-1:0] score_bcd,
   output logic [7*N_DIGITS-1:0] seg,
   output logic                  upd_pulse,
   output logic                  saturated
`ifdef SCORE_HISCORE_EN
   ,
   output logic [4*N_DIGITS-1:0] hi_bcd,
   output logic [7*N_DIGITS-1:0] hi_seg
`endif
);

   localparam int W = 4*N_DIGITS;
   localparam logic [W-1:0] NINES = {N_DIGITS{4'h9}};

   state_t                  state_q;
   logic [W-1:0]            score_q, score_d;
   logic [4*MAX_DIGITS-1:0] shadow_q, shadow_d;
   logic [3:0]              carry_q, carry_d;
   logic [2:0]              idx_q;
   logic                    sat_q, upd_q, last, commit;
   logic [4:0]              sum, adj;

   // shadow is padded to MAX_DIGITS so the digit index always spans it exactly
   always_comb begin
      sum = {1'b0, shadow_q[{idx_q, 2'b00} +: 4]} + {1'b0, carry_q};
      adj = sum > 5'd9 ? sum - 5'd10 : sum;
      carry_d = {3'b000, sum > 5'd9};
      shadow_d = shadow_q;
      shadow_d[{idx_q, 2'b00} +: 4] = adj[3:0];
      last = idx_q == 3'(N_DIGITS-1);
      score_d = carry_d[0] ? NINES : shadow_d[W-1:0];
      commit = rst_n && !clear && state_q == ADD && last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         score_q  <= '0;
         shadow_q <= '0;
         carry_q  <= '0;
         idx_q    <= '0;
         sat_q    <= 1'b0;
         upd_q    <= 1'b0;
      end else if (clear) begin
         state_q <= IDLE;
         score_q <= '0;
         sat_q   <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         if (state_q == IDLE) begin
            if (add_valid) begin
               state_q  <= ADD;
               shadow_q <= (4*MAX_DIGITS)'(score_q);
               carry_q  <= add_pts > 4'd9 ? 4'd9 : add_pts;
               idx_q    <= '0;
            end
         end else begin
            shadow_q <= shadow_d;
            carry_q  <= carry_d;
            idx_q    <= idx_q + 3'd1;
            if (last) begin
               state_q <= IDLE;
               upd_q   <= 1'b1;
               score_q <= score_d;
               sat_q   <= sat_q | carry_d[0];
            end
         end
      end
   end

   assign add_ready = state_q == IDLE;
   assign score_bcd = score_q;
   assign upd_pulse = upd_q;
   assign saturated = sat_q;

`ifdef SCORE_HISCORE_EN
   logic [W-1:0] hi_q;

   // packed BCD orders the same as unsigned binary, so a plain compare suffices
   always_ff @(posedge clk) begin
      if (!rst_n)
         hi_q <= '0;
      else if (commit && score_d > hi_q)
         hi_q <= score_d;
   end

   assign hi_bcd = hi_q;
`endif

   for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
      logic blank;
      assign blank = BLANK_LZ != 0 && k != 0 && score_q[W-1:4*k] == '0;
      seg7_digit_decoder u_dec (.bcd(score_q[4*k +: 4]), .blank(blank), .seg(seg[7*k +: 7]));
`ifdef SCORE_HISCORE_EN
      logic hi_blank;
      assign hi_blank = BLANK_LZ != 0 && k != 0 && hi_q[W-1:4*k] == '0;
      seg7_digit_decoder u_hi_dec (.bcd(hi_q[4*k +: 4]), .blank(hi_blank), .seg(hi_seg[7*k +: 7]));
`endif
   end

endmodule

// File: tb/tb_bcd_score_counter.sv
// tb_bcd_score_counter: directed self-checking bench for bcd_score_counter (N=4, BLANK_LZ=1).
module tb_bcd_score_counter;

   localparam logic [27:0] SEG_RST  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] SEG_9    = {7'h7F, 7'h7F, 7'h7F, 7'h18};
   localparam logic [27:0] SEG_103  = {7'h7F, 7'h79, 7'h40, 7'h30};
   localparam logic [27:0] SEG_9999 = {7'h18, 7'h18, 7'h18, 7'h18};
   localparam logic [27:0] SEG_120  = {7'h7F, 7'h79, 7'h24, 7'h40};
   localparam logic [27:0] SEG_50   = {7'h7F, 7'h7F, 7'h12, 7'h40};

   logic        clk = 1'b0;
   logic        rst_n, clear, add_valid, add_ready, upd_pulse, saturated;
   logic [3:0]  add_pts;
   logic [15:0] score_bcd;
   logic [27:0] seg;
`ifdef SCORE_HISCORE_EN
   logic [15:0] hi_bcd;
   logic [27:0] hi_seg;
`endif
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bcd_score_counter #(.N_DIGITS(4), .BLANK_LZ(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .add_valid(add_valid),
      .add_ready(add_ready),
      .add_pts(add_pts),
      .score_bcd(score_bcd),
      .seg(seg),
      .upd_pulse(upd_pulse),
      .saturated(saturated)
`ifdef SCORE_HISCORE_EN
      ,
      .hi_bcd(hi_bcd),
      .hi_seg(hi_seg)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // one full add transaction; the busy count is bounded so a stuck DUT cannot hang the run
   task automatic add(input logic [3:0] pts, input bit chk);
      int cnt;
      cnt = 0;
      @(negedge clk);
      add_valid = 1'b1;
      add_pts = pts;
      @(negedge clk);
      add_valid = 1'b0;
      while (!add_ready && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      if (chk) begin
         check("busy_cycles", cnt, 4);
         check("upd_pulse_hi", upd_pulse, 1);
      end
      @(negedge clk);
      if (chk)
         check("upd_pulse_lo", upd_pulse, 0);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      clear = 1'b0;
      add_valid = 1'b0;
      add_pts = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_score", score_bcd, 16'h0000);
      check("rst_seg", seg, SEG_RST);
      check("rst_ready", add_ready, 1);
      check("rst_sat", saturated, 0);
      check("rst_upd", upd_pulse, 0);
`ifdef SCORE_HISCORE_EN
      check("rst_hi", hi_bcd, 16'h0000);
`endif

      add(4'hF, 1);
      check("clamp_score", score_bcd, 16'h0009);
      check("clamp_seg", seg, SEG_9);

      repeat (9) add(4'd9, 0);
      add(4'd8, 0);
      check("score_98", score_bcd, 16'h0098);
      add(4'd5, 1);
      check("score_103", score_bcd, 16'h0103);
      check("seg_103", seg, SEG_103);

      pulse_clear();
      check("clear_score", score_bcd, 16'h0000);
      repeat (1110) add(4'd9, 0);
      add(4'd5, 0);
      check("score_9995", score_bcd, 16'h9995);
      check("sat_pre", saturated, 0);
      add(4'd9, 1);
      check("sat_score", score_bcd, 16'h9999);
      check("sat_flag", saturated, 1);
      check("sat_seg", seg, SEG_9999);
      add(4'd1, 1);
      check("sat_hold_score", score_bcd, 16'h9999);
      check("sat_hold_flag", saturated, 1);

      pulse_clear();
      check("clear_sat", saturated, 0);
      check("clear_score2", score_bcd, 16'h0000);
      repeat (4) add(4'd9, 0);
      add(4'd4, 0);
      check("score_40", score_bcd, 16'h0040);

      @(negedge clk);
      add_valid = 1'b1;
      add_pts = 4'd2;
      @(negedge clk);
      add_valid = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("abort_score", score_bcd, 16'h0000);
      check("abort_ready", add_ready, 1);
      check("abort_upd", upd_pulse, 0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen |= upd_pulse;
      end
      check("abort_no_upd", seen, 0);
      check("abort_score_late", score_bcd, 16'h0000);

      add(4'd9, 0);
      @(negedge clk);
      add_valid = 1'b1;
      add_pts = 4'd3;
      @(negedge clk);
      add_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_score", score_bcd, 16'h0000);
      check("mrst_seg", seg, SEG_RST);
      check("mrst_ready", add_ready, 1);
      check("mrst_sat", saturated, 0);
      check("mrst_upd", upd_pulse, 0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen |= upd_pulse;
      end
      check("mrst_no_upd", seen, 0);

`ifdef SCORE_HISCORE_EN
      check("mrst_hi", hi_bcd, 16'h0000);
      repeat (13) add(4'd9, 0);
      add(4'd3, 0);
      check("score_120", score_bcd, 16'h0120);
      pulse_clear();
      repeat (5) add(4'd9, 0);
      add(4'd5, 0);
      check("score_50", score_bcd, 16'h0050);
      check("seg_50", seg, SEG_50);
      check("hi_kept", hi_bcd, 16'h0120);
      check("hi_seg_120", hi_seg, SEG_120);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
